// File: rtl/lane_serializer.sv
// lane_serializer: captures an N-lane frame of 28-bit words and emits the lanes one per handshake
module lane_serializer #(
    parameter int N  = 4,
    parameter int LW = (N > 1) ? $clog2(N) : 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [N-1:0][27:0] in_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [27:0]        out_data,
    output logic [LW-1:0]      out_lane,
    output logic               out_last,
    output logic [15:0]        frame_cnt
);
    typedef enum logic {IDLE, SEND} state_t;

    localparam logic [LW-1:0] LAST = LW'(N - 1);

    state_t             state_q, state_d;
    logic [LW-1:0]      lane_q, lane_d;
    logic [N-1:0][27:0] buf_q, buf_d;
    logic [15:0]        frame_cnt_q, frame_cnt_d;
    logic               out_valid_q, out_valid_d;
    logic               out_last_q, out_last_d;
    logic [27:0]        out_data_q, out_data_d;
    logic               at_last, word_xfer, frame_done, frame_xfer;

    assign at_last    = lane_q == LAST;
    assign word_xfer  = out_valid_q && out_ready;
    assign frame_done = word_xfer && at_last;
    assign in_ready   = (state_q == IDLE) || frame_done;
    assign frame_xfer = in_valid && in_ready;

    // Next state: a finishing frame can hand over directly to a new one so frames stream without a bubble
    always_comb begin
        buf_d       = frame_xfer ? in_data : buf_q;
        state_d     = frame_xfer ? SEND : (frame_done ? IDLE : state_q);
        lane_d      = (frame_xfer || frame_done) ? '0 : (word_xfer ? lane_q + LW'(1) : lane_q);
        frame_cnt_d = frame_cnt_q + {15'd0, frame_done};
        out_valid_d = state_d == SEND;
        out_last_d  = (state_d == SEND) && (lane_d == LAST);
        out_data_d  = buf_d[lane_d];
    end

    // State and registered outputs; reset clears everything including the frame buffer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            lane_q      <= '0;
            buf_q       <= '0;
            frame_cnt_q <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            lane_q      <= lane_d;
            buf_q       <= buf_d;
            frame_cnt_q <= frame_cnt_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            out_data_q  <= out_data_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_lane  = lane_q;
    assign out_last  = out_last_q;
    assign frame_cnt = frame_cnt_q;
endmodule

// File: doc/lane_serializer.md
LANE_SERIALIZER -- requirements
Module: lane_serializer

Interface
REQ-001 Parameter N, default 4, number of 28-bit lanes in the packed input bus; legal range 1..16.
REQ-002 Parameter LW, default (N>1 ? $clog2(N) : 1), width of the lane index output; derived, not overridden.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low; one clock, async active-low reset (fixed).
REQ-005 in_valid  input  1  packed frame on in_data is offered.
REQ-006 in_ready  output  1  block accepts the offered frame this cycle.
REQ-007 in_data  input  [N-1:0][27:0]  packed frame; lane i = in_data[i].
REQ-008 out_valid  output  1  out_data holds a valid lane word.
REQ-009 out_ready  input  1  downstream accepts out_data this cycle.
REQ-010 out_data  output  28  current lane word.
REQ-011 out_lane  output  LW  index of the lane currently on out_data.
REQ-012 out_last  output  1  out_data is lane N-1 of its frame.
REQ-013 frame_cnt  output  16  count of fully emitted frames, wraps modulo 2^16.

Function
REQ-014 Frame transfer on in_valid && in_ready; word transfer on out_valid && out_ready.
REQ-015 State machine with states IDLE and SEND; reset state IDLE.
REQ-016 in_ready SHALL be 1 in IDLE, and in SEND only when out_valid && out_ready && out_lane==N-1; 0 otherwise (combinational from state, lane, out_ready).
REQ-017 On frame transfer the whole in_data SHALL be captured into an internal N x 28 buffer; lane counter set to 0; state SEND; out_valid=1 from the next cycle (latency 1 cycle).
REQ-018 In SEND, out_data SHALL equal buffer[lane], out_lane = lane, out_last = (lane==N-1); lanes emitted in order 0,1,...,N-1.
REQ-019 While out_valid && !out_ready, out_data, out_lane, out_last SHALL hold stable; no lane is skipped or repeated.
REQ-020 Word transfer with lane<N-1: lane increments by 1, stays in SEND.
REQ-021 Word transfer with lane==N-1: frame_cnt increments by 1; if in_valid in the same cycle, new frame captured, lane=0, stays SEND (no bubble); else state IDLE, out_valid=0 next cycle.
REQ-022 N=1: every word has out_lane=0 and out_last=1; back-to-back frames stream at one word per cycle.
REQ-023 in_data changes while in_ready=0 SHALL have no effect on buffer or outputs.
REQ-024 frame_cnt at 16'hFFFF SHALL wrap to 0 on the next completed frame.
REQ-025 Sustained throughput with out_ready held 1 and in_valid held 1: N words per N cycles, no idle cycle between frames.

Reset
REQ-026 rst_n low SHALL immediately force: state IDLE, out_valid=0, out_data=0, out_lane=0, out_last=0, frame_cnt=0, lane counter 0; buffer cleared to 0.
REQ-027 Reset asserted mid-frame SHALL discard remaining lanes; no partial frame counted; after release in_ready=1 in the first cycle.
REQ-028 Deassertion of rst_n is synchronised externally; block takes no transfer in the cycle rst_n rises.

Verification
REQ-029 N=4, in_data lanes {0xAAAAAAA,0x1111111,0x2222222,0x3333333} (lane3..0), out_ready=1 -> outputs 0x3333333,0x2222222,0x1111111,0xAAAAAAA on 4 consecutive cycles, lanes 0..3, out_last only on lane 3, frame_cnt=1.
REQ-030 Same frame, out_ready toggled 1,0,0,1,... -> each word held stable while stalled, order unchanged, in_ready=0 until lane-3 transfer.
REQ-031 in_valid held 1 with 3 distinct frames, out_ready=1 -> 12 words in 12 consecutive cycles, no gap, frame_cnt=3.
REQ-032 rst_n pulsed low after lane 1 transferred -> out_valid=0 asynchronously, frame_cnt=0, next frame restarts at lane 0.
REQ-033 N=1, in_valid=1 each cycle with values 1,2,3 -> out_data 1,2,3 on consecutive cycles, out_last=1 each.
REQ-034 Preload frame_cnt to 0xFFFF via 65535 frames (or force), one more frame -> frame_cnt=0.
